mctx_rr_drain: RTL and testbench
================================

Name: mctx_rr_drain

Overview:
- Downstream consumer of the multi-context linked-list queue.
- Each cycle, selects one non-empty, enabled context by round-robin and issues a one-hot get.
- Captures the same-cycle read data into a 2-entry output buffer and presents it on a valid/ready stream, tagged with the context index.
- A pause/drain state machine lets software quiesce the stream before reconfiguring contexts.

Parameters:
- NCTX, 16, number of contexts; must match the queue.
- WIDTH, 16, payload width; must match the queue.
- CTXW, $clog2(NCTX), context index width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- q_empty  input  NCTX  per-context empty flags from the queue.
- q_dout  input  WIDTH  queue read data, valid in the same cycle as q_get.
- q_get  output  1  dequeue strobe.
- q_gctx  output  NCTX  one-hot context select; all zero when q_get=0.
- ctx_en  input  NCTX  per-context drain enable.
- pause  input  1  request to stop issuing gets.
- pause_ack  output  1  high while in PAUSED.
- out_valid  output  1  output stream valid.
- out_ready  input  1  output stream ready.
- out_data  output  WIDTH  payload.
- out_ctx  output  CTXW  binary source context index.

Behaviour:
- Reset values: q_get=0, q_gctx=0, out_valid=0, out_data=0, out_ctx=0, pause_ack=0.
  - FIFO count=0, FSM=RUN, rr_ptr=NCTX-1, so the first grant searches from ctx 0.
- Eligibility: elig = ~q_empty & ctx_en.
- Issue condition: FSM==RUN, |elig, and buffer count<2 (registered count; no combinational path from out_ready to q_get).
- Grant: the lowest eligible index strictly above rr_ptr, wrapping modulo NCTX.
  - q_get and q_gctx are combinational from elig, rr_ptr, count and FSM.
  - On issue, rr_ptr <= granted index.
- Latency: q_dout and the granted index are written into the buffer at the issue clock edge. out_valid rises the next cycle. Get-to-output latency is 1 cycle.
- Output buffer: 2-entry FIFO holding {data, ctx}.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - out_data/out_ctx are driven from the head entry and are stable while out_valid=1 and out_ready=0.
  - Sustained throughput is 1 item/cycle when out_ready=1.
- Backpressure: count==2 blocks issue. Count never exceeds 2; push while full is impossible by construction.
- Single eligible context: it is granted every cycle it stays non-empty.
- Context disable: deasserting ctx_en[i] blocks new grants to i immediately. Items already buffered still drain.
- FSM:
  - RUN: pause=1 goes to DRAIN; no grant is issued in the cycle pause is seen.
  - DRAIN: no issue. count==0 goes to PAUSED. pause=0 returns to RUN.
  - PAUSED: pause_ack=1 (registered state decode). pause=0 goes to RUN; the first issue is possible the cycle after.
- Reset mid-operation: buffered items are discarded, rr_ptr returns to NCTX-1, FSM returns to RUN. The upstream queue is not told about discarded items; this is a system-level loss accepted on reset.

Optional Feature:
- Macro: MCTX_RR_DRAIN_STATS_EN.
- When defined, adds:
  - Input stat_sel [CTXW].
  - Input stat_clr [1].
  - Output stat_cnt [16].
  - Per-context 16-bit counters that increment on each issue to that context and saturate at 16'hFFFF.
  - stat_cnt = counter[stat_sel], combinational.
  - stat_clr zeroes all counters synchronously; clear wins over a same-cycle increment.
  - Counters reset to 0.
- When undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset; q_empty=all 1s, ctx_en=all 1s -> q_get=0, out_valid=0, pause_ack=0 for 10 cycles.
- Contexts 2, 5, 9 non-empty (ctx_en all 1s, out_ready=1), q_dout=0xA000+ctx -> grants 2,5,9,2,5,9 on consecutive cycles; out_ctx follows one cycle later; out_data=0xA002,0xA005,0xA009,...
- out_ready=0 with ctx 3 non-empty -> exactly 2 gets issued, then q_get=0. out_data holds the first item. Raising out_ready produces 2 outputs with no gap and gets resume.
- Ctx 0,1 non-empty, ctx_en[1]=0 -> only ctx 0 granted. Set ctx_en[1]=1 -> alternates 0,1.
- pause=1 with count=2, out_ready=1 -> no q_get from the next cycle. pause_ack=1 after 2 pops plus the state transition. pause=0 -> q_get resumes 1 cycle after leaving PAUSED.
- With MCTX_RR_DRAIN_STATS_EN: 3 gets to ctx 4, stat_sel=4 -> stat_cnt=3. Assert stat_clr -> 0. Preload to 0xFFFE and issue 2 gets -> 0xFFFF.

Source files
------------

// File: rtl/mctx_rr_drain_if.sv
// ---------------------------------------------------------------------------
// mctx_rr_drain_if
// Bundles every signal between the round-robin drain block, the upstream
// multi-context queue, software control and the downstream output stream.
//
// Parameters
//   NCTX  : number of contexts (must match the queue)
//   WIDTH : payload width (must match the queue)
//   CTXW  : context index width
//
// Signals
//   q_empty   [NCTX]  per-context empty flags from the queue
//   q_dout    [WIDTH] queue read data, valid in the cycle q_get is high
//   q_get             dequeue strobe
//   q_gctx    [NCTX]  one-hot context select (zero when q_get=0)
//   ctx_en    [NCTX]  per-context drain enable
//   pause             request to stop issuing gets
//   pause_ack         high while the drain block is quiesced
//   out_valid/out_ready  output stream handshake
//   out_data  [WIDTH] payload
//   out_ctx   [CTXW]  source context index
//
// Modports
//   master : the drain block
//   slave  : its environment (queue, software, downstream consumer)
// ---------------------------------------------------------------------------
interface mctx_rr_drain_if #(
  parameter int NCTX  = 16,
  parameter int WIDTH = 16,
  parameter int CTXW  = $clog2(NCTX)
);
  logic [NCTX-1:0]  q_empty;
  logic [WIDTH-1:0] q_dout;
  logic             q_get;
  logic [NCTX-1:0]  q_gctx;
  logic [NCTX-1:0]  ctx_en;
  logic             pause;
  logic             pause_ack;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CTXW-1:0]  out_ctx;

  modport master (
    input  q_empty, q_dout, ctx_en, pause, out_ready,
    output q_get, q_gctx, pause_ack, out_valid, out_data, out_ctx
  );

  modport slave (
    output q_empty, q_dout, ctx_en, pause, out_ready,
    input  q_get, q_gctx, pause_ack, out_valid, out_data, out_ctx
  );
endinterface

// File: rtl/mctx_rr_drain.sv
// ---------------------------------------------------------------------------
// mctx_rr_drain
// Round-robin consumer of the multi-context linked-list queue. Each cycle it
// picks one non-empty, enabled context (lowest index strictly above the last
// grant, wrapping), issues a one-hot get, and captures the same-cycle read
// data plus the context index into a 2-entry output FIFO that feeds a
// valid/ready stream. A RUN/DRAIN/PAUSED state machine lets software stop
// issuing gets and wait until the output buffer has emptied.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   bus        mctx_rr_drain_if.master (queue, control and output stream)
//   stat_sel   [CTXW] statistics counter select      (stats build only)
//   stat_clr          synchronous clear of all counters (stats build only)
//   stat_cnt   [16]   selected per-context issue count  (stats build only)
//
// Optional feature macro: MCTX_RR_DRAIN_STATS_EN
//   Adds per-context saturating 16-bit issue counters and the stat_* ports.
// ---------------------------------------------------------------------------
module mctx_rr_drain #(
  parameter int NCTX  = 16,
  parameter int WIDTH = 16,
  parameter int CTXW  = $clog2(NCTX)
) (
  input  logic                clk,
  input  logic                rst,
`ifdef MCTX_RR_DRAIN_STATS_EN
  input  logic [CTXW-1:0]     stat_sel,
  input  logic                stat_clr,
  output logic [15:0]         stat_cnt,
`endif
  mctx_rr_drain_if.master     bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic [CTXW:0] NCTX_W = (CTXW+1)'(NCTX);

  state_t            r_state;
  logic              r_pause_ack;
  logic [CTXW-1:0]   r_rr_ptr;

  // Output FIFO: two slots, a read pointer and an occupancy count.
  logic [WIDTH-1:0]  r_fifo_data [2];
  logic [CTXW-1:0]   r_fifo_ctx  [2];
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;

  logic [NCTX-1:0]   w_elig;
  logic              w_found;
  logic [CTXW-1:0]   w_grant_idx;
  logic [CTXW:0]     w_sum;
  logic              w_issue;
  logic              w_pop;
  logic              w_wr_idx;

  assign w_elig = ~bus.q_empty & bus.ctx_en;

  // Walk the candidates from farthest to nearest above rr_ptr so the last
  // hit (the nearest one) wins; the sum is one bit wider to handle the wrap.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int k = NCTX; k >= 1; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (CTXW+1)'(k);
      if (w_sum >= NCTX_W) w_sum = w_sum - NCTX_W;
      if (w_elig[w_sum[CTXW-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_sum[CTXW-1:0];
      end
    end
  end

  // Issue only from the registered count so out_ready never reaches q_get
  // combinationally; rst gating keeps q_get low for the whole reset pulse.
  assign w_issue  = !rst && (r_state == ST_RUN) && !bus.pause && w_found &&
                    (r_cnt < 2'd2);
  assign w_pop    = (r_cnt != 2'd0) && bus.out_ready;
  assign w_wr_idx = r_rd_ptr ^ r_cnt[0];

  assign bus.q_get     = w_issue;
  assign bus.q_gctx    = w_issue ? (NCTX'(1) << w_grant_idx) : '0;
  assign bus.out_valid = (r_cnt != 2'd0);
  assign bus.out_data  = r_fifo_data[r_rd_ptr];
  assign bus.out_ctx   = r_fifo_ctx[r_rd_ptr];
  assign bus.pause_ack = r_pause_ack;

  // Round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= CTXW'(NCTX-1);
    end else if (w_issue) begin
      r_rr_ptr <= w_grant_idx;
    end
  end

  // Output FIFO: the queue's same-cycle read data lands here at the issue edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_ctx[0]  <= '0;
      r_fifo_ctx[1]  <= '0;
      r_rd_ptr       <= 1'b0;
      r_cnt          <= 2'd0;
    end else begin
      if (w_issue) begin
        r_fifo_data[w_wr_idx] <= bus.q_dout;
        r_fifo_ctx[w_wr_idx]  <= w_grant_idx;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_issue, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Pause/drain FSM; pause_ack is registered alongside the PAUSED state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pause_ack <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.pause) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.pause) begin
            r_state <= ST_RUN;
          end else if (r_cnt == 2'd0) begin
            r_state     <= ST_PAUSED;
            r_pause_ack <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!bus.pause) begin
            r_state     <= ST_RUN;
            r_pause_ack <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_pause_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef MCTX_RR_DRAIN_STATS_EN
  logic [15:0] r_stat [NCTX];

  // Clear has priority over a same-cycle increment; counts saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCTX; i++) r_stat[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NCTX; i++) r_stat[i] <= '0;
    end else if (w_issue && (r_stat[w_grant_idx] != 16'hFFFF)) begin
      r_stat[w_grant_idx] <= r_stat[w_grant_idx] + 16'd1;
    end
  end

  assign stat_cnt = r_stat[stat_sel];
`endif

endmodule

// File: tb/tb_mctx_rr_drain.sv
// ---------------------------------------------------------------------------
// tb_mctx_rr_drain
// Self-checking bench for mctx_rr_drain. A reference model (queue of buffered
// items, round-robin pointer, pause state, per-context counters) predicts
// every output each cycle; directed phases follow the test plan, followed by
// randomized traffic with occasional mid-run resets.
// ---------------------------------------------------------------------------
module tb_mctx_rr_drain;
  localparam int NCTX  = 16;
  localparam int WIDTH = 16;
  localparam int CTXW  = 4;

  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_PAUSED = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mctx_rr_drain_if #(.NCTX(NCTX), .WIDTH(WIDTH), .CTXW(CTXW)) bus ();

`ifdef MCTX_RR_DRAIN_STATS_EN
  logic [CTXW-1:0] stat_sel;
  logic            stat_clr;
  logic [15:0]     stat_cnt;
`endif

  mctx_rr_drain #(.NCTX(NCTX), .WIDTH(WIDTH), .CTXW(CTXW)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MCTX_RR_DRAIN_STATS_EN
    .stat_sel (stat_sel),
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt),
`endif
    .bus      (bus.master)
  );

  // Upstream queue stand-in: in tag mode it returns 0xA000+ctx for the
  // selected context, otherwise a random word chosen per cycle.
  logic             tag_mode;
  logic [WIDTH-1:0] rnd_dout;

  function automatic logic [WIDTH-1:0] onehot_idx(logic [NCTX-1:0] oh);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NCTX; i++) if (oh[i]) r = WIDTH'(i);
    return r;
  endfunction

  always_comb begin
    bus.q_dout = tag_mode ? (16'hA000 + onehot_idx(bus.q_gctx)) : rnd_dout;
  end

  // Reference model
  logic [WIDTH+CTXW-1:0] m_q[$];
  int                    m_ptr;
  int                    m_st;
  int                    m_stat [NCTX];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void mreset();
    m_q.delete();
    m_ptr = NCTX - 1;
    m_st  = M_RUN;
    for (int i = 0; i < NCTX; i++) m_stat[i] = 0;
  endfunction

  function automatic int find_grant(int ptr, logic [NCTX-1:0] elig);
    for (int k = 1; k <= NCTX; k++) begin
      int j;
      j = (ptr + k) % NCTX;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, then leave the caller 1 time unit after the edge.
  task automatic cycle_chk();
    logic [NCTX-1:0]  elig;
    logic [NCTX-1:0]  egctx;
    logic [WIDTH-1:0] edata;
    int               g;
    bit               iss;
    bit               pop;
    @(negedge clk);
    elig  = ~bus.q_empty & bus.ctx_en;
    g     = find_grant(m_ptr, elig);
    iss   = !rst && (m_st == M_RUN) && !bus.pause && (g >= 0) && (m_q.size() < 2);
    egctx = iss ? (NCTX'(1) << g) : '0;
    edata = tag_mode ? (16'hA000 + WIDTH'(g)) : rnd_dout;
    pop   = (m_q.size() > 0) && bus.out_ready;
    check("q_get", 32'(bus.q_get), 32'(iss));
    check("q_gctx", 32'(bus.q_gctx), 32'(egctx));
    check("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    check("pause_ack", 32'(bus.pause_ack), 32'(m_st == M_PAUSED));
    if (m_q.size() > 0) begin
      check("out_data", 32'(bus.out_data), 32'(m_q[0][WIDTH+CTXW-1:CTXW]));
      check("out_ctx", 32'(bus.out_ctx), 32'(m_q[0][CTXW-1:0]));
    end
`ifdef MCTX_RR_DRAIN_STATS_EN
    check("stat_cnt", 32'(stat_cnt), 32'(m_stat[stat_sel]));
`endif
    @(posedge clk);
    if (!rst) begin
      case (m_st)
        M_RUN:    if (bus.pause) m_st = M_DRAIN;
        M_DRAIN:  if (!bus.pause) m_st = M_RUN; else if (m_q.size() == 0) m_st = M_PAUSED;
        default:  if (!bus.pause) m_st = M_RUN;
      endcase
      if (pop) void'(m_q.pop_front());
      if (iss) begin
        m_q.push_back({edata, CTXW'(g)});
        m_ptr = g;
      end
`ifdef MCTX_RR_DRAIN_STATS_EN
      if (stat_clr) begin
        for (int i = 0; i < NCTX; i++) m_stat[i] = 0;
      end else if (iss && m_stat[g] < 16'hFFFF) begin
        m_stat[g]++;
      end
`endif
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_chk();
  endtask

  initial begin
    rst           = 1'b1;
    tag_mode      = 1'b1;
    rnd_dout      = '0;
    bus.q_empty   = '1;
    bus.ctx_en    = '1;
    bus.pause     = 1'b0;
    bus.out_ready = 1'b1;
`ifdef MCTX_RR_DRAIN_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
    mreset();
    #1;
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_ctx", 32'(bus.out_ctx), 32'h0);
    run(3);
    rst = 1'b0;

    // Idle after reset: nothing eligible
    run(10);

    // Contexts 2, 5, 9 rotate
    bus.q_empty = ~16'h0224;
    run(8);
    bus.q_empty = '1;
    run(3);

    // Backpressure with a single eligible context
    bus.q_empty   = ~16'h0008;
    bus.out_ready = 1'b0;
    run(5);
    bus.out_ready = 1'b1;
    run(5);
    bus.q_empty = '1;
    run(3);

    // Context enable gating
    bus.q_empty = ~16'h0003;
    bus.ctx_en  = ~16'h0002;
    run(6);
    bus.ctx_en  = '1;
    run(6);
    bus.q_empty = '1;
    run(3);

    // Pause with a full buffer, then resume
    bus.q_empty   = ~16'h0008;
    bus.out_ready = 1'b0;
    run(3);
    bus.pause     = 1'b1;
    bus.out_ready = 1'b1;
    run(8);
    check("paused_ack", 32'(bus.pause_ack), 32'h1);
    bus.pause = 1'b0;
    run(5);
    bus.q_empty = '1;
    run(3);

`ifdef MCTX_RR_DRAIN_STATS_EN
    bus.q_empty = ~16'h0010;
    stat_sel    = 4'd4;
    run(3);
    bus.q_empty = '1;
    run(1);
    check("stat_three", 32'(stat_cnt), 32'd3);
    stat_clr = 1'b1;
    run(1);
    stat_clr = 1'b0;
    run(1);
    check("stat_clear", 32'(stat_cnt), 32'd0);
    bus.q_empty = ~16'h0010;
    run(65534 + 4);
    check("stat_sat", 32'(stat_cnt), 32'hFFFF);
    bus.q_empty = '1;
    run(2);
`endif

    // Randomized traffic with occasional mid-run resets
    tag_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.q_empty   = NCTX'($urandom) | NCTX'($urandom);
      bus.ctx_en    = ($urandom_range(0, 3) == 0) ? NCTX'($urandom) : '1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rnd_dout      = WIDTH'($urandom);
      if ($urandom_range(0, 24) == 0) bus.pause = ~bus.pause;
`ifdef MCTX_RR_DRAIN_STATS_EN
      stat_sel = CTXW'($urandom);
      stat_clr = ($urandom_range(0, 99) == 0);
`endif
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        mreset();
      end else begin
        rst = 1'b0;
      end
      cycle_chk();
    end
    rst = 1'b0;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
